// File: rtl/gfx_pkg.sv
// Shared types and pixel helpers for the render back end.
// Helpers run at the widest supported line width; callers truncate to their own MDW.
package gfx_pkg;

  localparam int MAX_MDW = 512;
  localparam int MAX_MBW = 9;

  typedef enum logic [1:0] {
    WC_IDLE,
    WC_MERGE,
    WC_READ,
    WC_WRITE
  } wc_state_e;

  localparam logic [MAX_MDW-1:0] LSB1 = {{(MAX_MDW-1){1'b0}}, 1'b1};

  function automatic logic [MAX_MDW-1:0] fnPixelMask(input logic [5:0]         bpp,
                                                     input logic [MAX_MBW-1:0] mb,
                                                     input int                 mdw);
    logic [MAX_MDW-1:0] m;
    m = (LSB1 << bpp) - LSB1;
    m = m << mb;
    for (int i = 0; i < MAX_MDW; i++) begin
      if (i >= mdw) m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [MAX_MDW/8-1:0] fnByteSel(input logic [MAX_MDW-1:0] mask);
    logic [MAX_MDW/8-1:0] s;
    for (int i = 0; i < MAX_MDW/8; i++) begin
      s[i] = |mask[8*i +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/gfx_pixel_fifo.sv
// Generic valid/ready FIFO with an occupancy count; power-of-two depth.
module gfx_pixel_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  input  logic [W-1:0]  push_data_i,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output logic [W-1:0]  pop_data_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          push, pop;

  assign push_ready_o = (cnt != CW'(DEPTH));
  assign pop_valid_o  = (cnt != '0);
  assign pop_data_o   = mem[rd_ptr];
  assign count_o      = cnt;
  assign push         = push_valid_i & push_ready_o;
  assign pop          = pop_valid_o & pop_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/gfx_renderer_wc.sv
// Write-combining pixel back end: merges same-line pixels into one bus write,
// with optional read-modify-write, idle timeout and explicit flush.
//
//   state    | meaning
//   WC_IDLE  | no open line; waits for a pixel or a pending flush
//   WC_MERGE | line open; pops matching pixels into the line buffer
//   WC_READ  | fetching the line before merging (rmw mode)
//   WC_WRITE | bus write of the line held until acknowledged
module gfx_renderer_wc
  import gfx_pkg::*;
#(
  parameter int MDW        = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int MBW        = $clog2(MDW)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             px_valid_i,
  output logic             px_ready_o,
  input  logic [31:0]      px_addr_i,
  input  logic [MBW-1:0]   px_mb_i,
  input  logic [31:0]      px_color_i,
  input  logic [5:0]       bpp_i,
  input  logic             rmw_i,
  input  logic             flush_i,
  output logic             idle_o,
  output logic             write_o,
  output logic             read_o,
  output logic [31:0]      render_addr_o,
  output logic [MDW/8-1:0] render_sel_o,
  output logic [MDW-1:0]   render_dat_o,
  input  logic [MDW-1:0]   render_dat_i,
  input  logic             ack_i
);

  localparam int SW = MDW / 8;
  localparam int LB = $clog2(SW);
  localparam int FW = 32 + MBW + 32;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  wc_state_e      state;
  logic [31:0]    line_addr;
  logic [MDW-1:0] data_q;
  logic [SW-1:0]  sel_q;
  logic           buf_valid;
  logic           flush_pending;
  logic           rdy_en;
  logic [TW-1:0]  tcnt;

  logic           fifo_push_ready, fifo_vld, pop;
  logic [FW-1:0]  fifo_dout;
  logic [CW-1:0]  fifo_cnt;

  logic [31:0]          head_addr, head_line, head_color;
  logic [MBW-1:0]       head_mb;
  logic                 hit, timeout_hit;
  logic [MAX_MDW-1:0]   mask_w, color_w;
  logic [MAX_MDW/8-1:0] bsel_w;
  logic                 unused_bits;

  // rdy_en holds off input until the first clock after reset release
  assign px_ready_o = rdy_en & fifo_push_ready & ~flush_pending;
  assign idle_o     = (state == WC_IDLE) && (fifo_cnt == '0) && !buf_valid;

  gfx_pixel_fifo #(.W(FW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_valid_i (px_valid_i & rdy_en & ~flush_pending),
    .push_ready_o (fifo_push_ready),
    .push_data_i  ({px_addr_i, px_mb_i, px_color_i}),
    .pop_valid_o  (fifo_vld),
    .pop_ready_i  (pop),
    .pop_data_o   (fifo_dout),
    .count_o      (fifo_cnt)
  );

  assign head_addr  = fifo_dout[FW-1 -: 32];
  assign head_mb    = fifo_dout[32 +: MBW];
  assign head_color = fifo_dout[31:0];
  assign head_line  = {head_addr[31:LB], {LB{1'b0}}};

  assign hit         = fifo_vld && (head_line == line_addr);
  assign pop         = (state == WC_MERGE) && hit;
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT));

  assign mask_w  = fnPixelMask(bpp_i, MAX_MBW'(head_mb), MDW);
  assign color_w = ({{(MAX_MDW-32){1'b0}}, head_color} << MAX_MBW'(head_mb)) & mask_w;
  assign bsel_w  = fnByteSel(mask_w);

  assign unused_bits = ^{mask_w, color_w, bsel_w, head_addr[LB-1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= WC_IDLE;
      line_addr     <= '0;
      data_q        <= '0;
      sel_q         <= '0;
      buf_valid     <= 1'b0;
      flush_pending <= 1'b0;
      rdy_en        <= 1'b0;
      tcnt          <= '0;
      write_o       <= 1'b0;
      read_o        <= 1'b0;
      render_addr_o <= '0;
      render_sel_o  <= '0;
      render_dat_o  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (idle_o)       flush_pending <= 1'b0;
      else if (flush_i) flush_pending <= 1'b1;

      case (state)
        WC_IDLE: begin
          if (fifo_vld && !buf_valid) begin
            line_addr <= head_line;
            if (rmw_i) begin
              read_o        <= 1'b1;
              render_addr_o <= head_line;
              render_sel_o  <= '1;
              state         <= WC_READ;
            end else begin
              data_q    <= '0;
              sel_q     <= '0;
              buf_valid <= 1'b1;
              state     <= WC_MERGE;
            end
          end else if (flush_pending && buf_valid) begin
            write_o       <= 1'b1;
            render_addr_o <= line_addr;
            render_sel_o  <= sel_q;
            render_dat_o  <= data_q;
            state         <= WC_WRITE;
          end
        end

        WC_READ: begin
          if (ack_i) begin
            data_q    <= render_dat_i;
            sel_q     <= '1;
            read_o    <= 1'b0;
            buf_valid <= 1'b1;
            state     <= WC_MERGE;
          end
        end

        WC_MERGE: begin
          if (hit) begin
            data_q <= (data_q & ~mask_w[MDW-1:0]) | color_w[MDW-1:0];
            sel_q  <= rmw_i ? '1 : (sel_q | bsel_w[SW-1:0]);
            tcnt   <= '0;
          end else if (fifo_vld || flush_pending || timeout_hit) begin
            write_o       <= 1'b1;
            render_addr_o <= line_addr;
            render_sel_o  <= sel_q;
            render_dat_o  <= data_q;
            tcnt          <= '0;
            state         <= WC_WRITE;
          end else if (TIMEOUT > 0) begin
            tcnt <= tcnt + TW'(1);
          end
        end

        WC_WRITE: begin
          if (ack_i) begin
            write_o   <= 1'b0;
            buf_valid <= 1'b0;
            sel_q     <= '0;
            state     <= WC_IDLE;
          end
        end

        default: state <= WC_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gfx_renderer_wc.md
Name: gfx_renderer_wc

Overview:
- Next-generation pixel render back end with a parametrised memory data width.
- Accepts a stream of pre-addressed pixels through a valid/ready FIFO and merges consecutive pixels that fall in the same memory line into one line buffer (write combining).
- Issues one bus write per line instead of one per pixel, with optional read-modify-write for sub-byte colour depths, timeout flush and explicit flush.
- Sits between the address-calculation stage and the memory bus master.

Parameters:
- MDW, 256, memory data width in bits; power of two, 32..512.
- FIFO_DEPTH, 8, input pixel FIFO entries; power of two, minimum 2.
- TIMEOUT, 16, idle cycles with a partially filled line before an automatic flush; 0 disables the timeout.
- MBW, $clog2(MDW), width of the bit-offset field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- px_valid_i  in  1  pixel present
- px_ready_o  out  1  FIFO can accept a pixel
- px_addr_i  in  32  line-aligned byte address (bits [$clog2(MDW/8)-1:0] ignored)
- px_mb_i  in  MBW  bit offset of the pixel within the line
- px_color_i  in  32  colour, right-justified
- bpp_i  in  6  bits per pixel, 1..32; quasi-static
- rmw_i  in  1  read line before merging; quasi-static
- flush_i  in  1  request to drain FIFO and line buffer
- idle_o  out  1  FIFO empty, line buffer empty, no bus cycle active
- write_o  out  1  bus write request
- read_o  out  1  bus read request
- render_addr_o  out  32  bus address
- render_sel_o  out  MDW/8  byte enables
- render_dat_o  out  MDW  write data
- render_dat_i  in  MDW  read data
- ack_i  in  1  bus acknowledge; completes the current read or write

Behaviour:
- Reset (rst_ni=0, asynchronous): all bus outputs, render_addr_o, render_sel_o and render_dat_o = 0; px_ready_o=0; FIFO empty; line buffer invalid; flush_pending=0; timeout counter=0; state IDLE; idle_o=1. Reset asserted mid-bus-cycle drops the request immediately; buffered pixels are discarded.
- FIFO: a pixel is pushed when px_valid_i & px_ready_o. px_ready_o = !full & !flush_pending. Push and pop may occur in the same cycle. Minimum input-to-merge latency is 2 cycles.
- States: IDLE, MERGE, READ, WRITE.
- IDLE:
  - FIFO non-empty and buffer invalid: latch the head address as line_addr. If rmw_i, go to READ; otherwise clear data and sel, set the buffer valid, go to MERGE.
  - Else if flush_pending and buffer valid: go to WRITE.
- READ: read_o=1, render_addr_o=line_addr, render_sel_o all ones. On ack_i, data=render_dat_i, read_o=0, buffer valid, go to MERGE.
- MERGE: pop one pixel per cycle while the head address equals line_addr.
  - mask = ((1<<bpp_i)-1)<<px_mb_i, truncated to MDW bits; data = (data & ~mask) | ((color & ((1<<bpp_i)-1))<<px_mb_i).
  - Non-rmw: sel |= every byte that overlaps mask.
  - Rmw: sel = all ones.
  - Later pixels overwrite earlier pixels at the same offset.
- Leaving MERGE for WRITE (without popping the head pixel) on any of:
  - head address differs from line_addr;
  - flush_pending with FIFO empty;
  - timeout counter reaches TIMEOUT.
- Timeout counter: counts cycles in MERGE with the FIFO empty; resets on every pop.
- WRITE: write_o=1, render_addr_o=line_addr, render_sel_o=sel, render_dat_o=data. On ack_i, write_o=0, buffer invalid, sel=0, go to IDLE. The write is held until ack_i; there is no abort.
- Non-rmw mode with bpp_i not a multiple of 8 zeroes the untouched bits in partially covered bytes. Callers must set rmw_i for such depths; the block does not check this.
- flush_i: sets flush_pending, which blocks new input. flush_pending clears in the cycle idle_o becomes 1. flush_i while already idle has no effect.
- idle_o is combinational from state, FIFO count and buffer valid.
- Only one of read_o/write_o is ever high. Bus outputs are registered.

Decomposition:
- gfx_pkg gains:
  - wc_state_e enum (IDLE, MERGE, READ, WRITE);
  - function fnPixelMask(bpp, mb, MDW);
  - function fnByteSel(mask).
- Sub-module gfx_pixel_fifo (parametrised width/depth, valid/ready, count output), reusable by other pipeline stages.

Test Plan:
- MDW=256, rmw_i=0, bpp=16: 16 pixels at addr 0x1000, mb 0,16..240, colours 0x0001..0x0010 -> exactly one write, addr 0x1000, sel 0xFFFFFFFF, dat[15:0]=0x0001, dat[255:240]=0x0010.
- Alternating addresses 0x1000/0x1020, bpp=32, 4 pixels -> 4 writes in input order; each sel has only 4 bytes set (0x0000000F for mb=0).
- rmw_i=1, bpp=4, read returns all 0xF, pixel mb=8 colour 0x3 -> read then write; dat byte1=0xF3, all other bits 1, sel all ones.
- TIMEOUT=16, single pixel then no input -> write_o rises 17±1 cycles after the pop; idle_o=1 after ack.
- flush_i with 3 FIFO entries and ack_i delayed 5 cycles -> px_ready_o=0 until idle_o=1; all pixels written before idle.
- rst_ni pulsed low while write_o=1 -> write_o=0 asynchronously; after release, idle_o=1 and the old data is never written.
